spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Byte-level consumer sitting directly downstream of the SPI slave shifter.
- Takes its received byte (dout) and byte-complete pulse (done), and drives its transmit byte (din).
- Decodes a command byte, then streams writes into, or reads out of, a small register bank.
- The register bank contents are exposed as a flat output bus for the rest of the chip.

Parameters:
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W, legal range 1..7.
- STATUS_BYTE, 8'hA5, byte presented on din while idle and during the read turnaround byte.

Ports:
- clk  input  1  single system clock, same clock as the SPI slave.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ss  input  1  raw slave-select pin, active-low; synchronised internally with 2 flops.
- done  input  1  one-cycle pulse from the slave: a byte has completed.
- dout  input  8  received byte; valid in the cycle done=1.
- din  output  8  next byte to transmit; registered (din_q).
- regs  output  8*NUM_REGS  register bank; reg k occupies bits [8k+7:8k].
- wr_stb  output  1  one-cycle pulse when a register is written.
- wr_addr  output  ADDR_W  address of the write; valid with wr_stb.
- busy  output  1  high when state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, addr=0, din=STATUS_BYTE, all regs=8'h00.
  - wr_stb=0, wr_addr=0, ss sync flops = 1 (deselected).
- Command byte (first done while state=IDLE):
  - bit7=1 selects WRITE, bit7=0 selects READ.
  - addr <= cmd[ADDR_W-1:0]; cmd bits [6:ADDR_W] are ignored.
- States:
  - IDLE: on done, go to WRITE or READ per bit7. On entry to READ, din <= regs[cmd addr] on the next edge.
  - WRITE: on each done, regs[addr] <= dout, wr_stb=1 and wr_addr=addr in the following cycle, then addr <= addr+1.
  - READ: on each done, addr <= addr+1 and din <= regs[addr+1].
- Read timing: the slave loads din at the end of each byte, one cycle before done is seen here. Therefore:
  - MISO byte 0 (the command byte) shifts STATUS_BYTE.
  - Byte 1 after the command is the turnaround byte and shifts STATUS_BYTE.
  - Bytes 2, 3, ... shift regs[A], regs[A+1], ...
- Latency: din and regs update 1 clk after done; wr_stb asserts 1 clk after done.
- Address wrap: addr increments modulo NUM_REGS, so address NUM_REGS-1 is followed by 0.
- Deselect (synchronised ss=1): state <= IDLE and din <= STATUS_BYTE.
  - This is an abort at any point; a partially received byte is simply never seen because no done arrives.
- done and deselect in the same cycle: the done action commits first (a write is performed and wr_stb fires), then state is IDLE.
- Registers written in one cycle are visible on regs the next cycle.
- Reading the register most recently written returns the new value.

Optional Feature:
- Macro SPI_REG_BRIDGE_AUTOINC_EN.
- Defined: address auto-increments after each data byte, as described above.
- Undefined: addr stays at the command address for the whole transaction.
  - Repeated writes overwrite one register; repeated reads return the same register.
  - The increment logic is removed.

Decomposition:
- Package spi_reg_bridge_pkg:
  - state enum: IDLE, WRITE, READ.
  - CMD_WR_BIT = 7.
  - default STATUS_BYTE.
- One sub-module: spi_reg_bridge_sync, a 2-flop synchroniser for ss that resets to 1.
- Everything else is flat.

Test Plan:
- Reset: hold rst=0 with done pulses → regs=0, din=8'hA5, busy=0, no wr_stb; on release, state=IDLE.
- Write burst: ss low, bytes 8'h82, 8'h11, 8'h22 → reg2=8'h11, reg3=8'h22; two wr_stb pulses with wr_addr 2 then 3.
- Read burst with regs 5..7 = 8'h55/66/77: bytes 8'h05, dummy, x, x, x → din sequence A5, 55, 66, 77, 00 (wrap to reg0); MISO returns A5, A5, 55, 66, 77.
- Wrap on write: cmd 8'h87 then 3 data bytes → reg7, reg0, reg1 written, in that order.
- Abort: ss high after the command plus 3 sck edges of data → state=IDLE, din=A5, no register changes; the next command decodes correctly.
- Macro undefined: cmd 8'h84, data 8'h01, 8'h02 → reg4=8'h02, reg5 unchanged; reading from 4 twice returns 02, 02.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// rtl/spi_reg_bridge_pkg.sv - shared state encoding and constants for the SPI register bridge
package spi_reg_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  localparam int         CMD_WR_BIT          = 7;
  localparam logic [7:0] DEFAULT_STATUS_BYTE = 8'hA5;

endpackage

// File: rtl/spi_reg_bridge_sync.sv
// rtl/spi_reg_bridge_sync.sv - two-flop synchroniser for slave select, resets to deselected
module spi_reg_bridge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - command decoder and register bank behind an SPI slave byte interface
// Optional address auto-increment is enabled by defining SPI_REG_BRIDGE_AUTOINC_EN.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 3,
  parameter logic [7:0] STATUS_BYTE = DEFAULT_STATUS_BYTE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ss,
  input  logic                        done,
  input  logic [7:0]                  dout,
  output logic [7:0]                  din,
  output logic [8*(2**ADDR_W)-1:0]    regs,
  output logic                        wr_stb,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic                        busy
);

  localparam int NUM_REGS = 2**ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          din_q, din_d;
  logic [7:0]          regs_q [NUM_REGS];
  logic [7:0]          regs_d [NUM_REGS];
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic                ss_sync;

  spi_reg_bridge_sync u_ss_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (ss),
    .sync_o  (ss_sync)
  );

  assign cmd_addr = dout[ADDR_W-1:0];

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  assign next_addr = addr_q + 1'b1;
`else
  assign next_addr = addr_q;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (done) begin
          addr_d = cmd_addr;
          if (dout[CMD_WR_BIT]) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
            din_d   = regs_q[cmd_addr];
          end
        end
      end
      WRITE: begin
        if (done) begin
          regs_d[addr_q] = dout;
          wr_stb_d       = 1'b1;
          wr_addr_d      = addr_q;
          addr_d         = next_addr;
        end
      end
      READ: begin
        // din is loaded one byte ahead of the shifter, hence the turnaround byte
        if (done) begin
          addr_d = next_addr;
          din_d  = regs_q[next_addr];
        end
      end
      default: state_d = IDLE;
    endcase
    // Deselect aborts after any coincident done has been committed above
    if (ss_sync) begin
      state_d = IDLE;
      din_d   = STATUS_BYTE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= STATUS_BYTE;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs[8*g +: 8] = regs_q[g];
  end

  assign din     = din_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge; honours SPI_REG_BRIDGE_AUTOINC_EN
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        done;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic [63:0] regs;
  logic        wr_stb;
  logic [2:0]  wr_addr;
  logic        busy;

  spi_reg_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .ss      (ss),
    .done    (done),
    .dout    (dout),
    .din     (din),
    .regs    (regs),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] mreg [8];
  int         stb_cnt = 0;
  int         last_wa = 0;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt++;
      last_wa = int'(wr_addr);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < 8; k++) chk(name, {24'd0, regs[8*k +: 8]}, {24'd0, mreg[k]});
  endtask

  // Expected values come from transaction arithmetic: data byte j targets (A + j*INC) mod 8
  task automatic do_txn(input logic [7:0] b [8], input int n);
    logic [7:0] a;
    logic       wr;
    a  = {5'd0, b[0][2:0]};
    wr = b[0][7];
    ss = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("miso_byte0", {24'd0, din}, 32'hA5);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      if (wr || k < 1) chk("miso_next", {24'd0, din}, 32'hA5);
      else chk("miso_next", {24'd0, din}, {24'd0, mreg[(a + (k - 1) * INC) % 8]});
      @(posedge clk);
      #1;
      done = 1'b1;
      dout = b[k];
      @(posedge clk);
      #1;
      done = 1'b0;
      if (wr && k > 0) mreg[(a + (k - 1) * INC) % 8] = b[k];
      @(negedge clk);
      chk("busy_txn", {31'd0, busy}, 32'd1);
      if (wr) chk("din_wr", {24'd0, din}, 32'hA5);
      else chk("din_rd", {24'd0, din}, {24'd0, mreg[(a + k * INC) % 8]});
      chk("wr_stb", {31'd0, wr_stb}, {31'd0, (wr && k > 0)});
      if (wr && k > 0) chk("wr_addr", {29'd0, wr_addr}, (a + (k - 1) * INC) % 8);
    end
    ss = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("din_end", {24'd0, din}, 32'hA5);
    check_regs("regs_end");
  endtask

  typedef struct {
    logic [7:0] b [8];
    int         n;
    int         chk_addr;
    logic [7:0] chk_val;
    int         stb_exp;
    int         wa_exp;
  } vec_t;

  vec_t       tbl [3];
  logic [7:0] bb [8];
  int         stb0;

  initial begin
    for (int k = 0; k < 8; k++) mreg[k] = 8'h00;
    for (int k = 0; k < 8; k++) bb[k] = 8'h00;
    tbl[0].b = '{8'h82, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[0].n = 3; tbl[0].chk_addr = 2; tbl[0].chk_val = INC ? 8'h11 : 8'h22;
    tbl[0].stb_exp = 2; tbl[0].wa_exp = INC ? 3 : 2;
    tbl[1].b = '{8'h87, 8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].n = 4; tbl[1].chk_addr = 0; tbl[1].chk_val = INC ? 8'hB2 : 8'h00;
    tbl[1].stb_exp = 3; tbl[1].wa_exp = INC ? 1 : 7;
    tbl[2].b = '{8'h84, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].n = 3; tbl[2].chk_addr = 4; tbl[2].chk_val = INC ? 8'h01 : 8'h02;
    tbl[2].stb_exp = 2; tbl[2].wa_exp = INC ? 5 : 4;

    rst = 1'b0; ss = 1'b0; done = 1'b0; dout = 8'h00;
    repeat (3) begin
      @(posedge clk); #1; done = 1'b1; dout = 8'h83;
      @(posedge clk); #1; done = 1'b0;
    end
    @(negedge clk);
    check_regs("reset_regs");
    chk("reset_din", {24'd0, din}, 32'hA5);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_stb", stb_cnt, 32'd0);
    chk("reset_wa", {29'd0, wr_addr}, 32'd0);
    ss = 1'b1;
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      stb0 = stb_cnt;
      do_txn(tbl[i].b, tbl[i].n);
      chk("tbl_reg", {24'd0, regs[8*tbl[i].chk_addr +: 8]}, {24'd0, tbl[i].chk_val});
      chk("tbl_stb_cnt", stb_cnt - stb0, tbl[i].stb_exp);
      chk("tbl_last_wa", last_wa, tbl[i].wa_exp);
    end

    bb = '{8'h85, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn(bb, 2);
    bb[0] = 8'h86; bb[1] = 8'h66; do_txn(bb, 2);
    bb[0] = 8'h87; bb[1] = 8'h77; do_txn(bb, 2);
    bb = '{8'h05, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00}; do_txn(bb, 5);
    bb = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn(bb, 4);

    // Abort: command only, then deselect mid-byte; next command must still decode
    bb = '{8'h83, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn(bb, 1);
    bb = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; do_txn(bb, 3);

    // done coincides with the synchronised deselect: write commits, state returns to IDLE
    ss = 1'b0;
    repeat (3) @(posedge clk);
    #1; done = 1'b1; dout = 8'h81;
    @(posedge clk); #1; done = 1'b0;
    @(posedge clk); #1; ss = 1'b1;
    @(posedge clk); @(posedge clk); #1; done = 1'b1; dout = 8'h5A;
    @(posedge clk); #1; done = 1'b0;
    mreg[1] = 8'h5A;
    @(negedge clk);
    chk("coinc_stb", {31'd0, wr_stb}, 32'd1);
    chk("coinc_wa", {29'd0, wr_addr}, 32'd1);
    chk("coinc_busy", {31'd0, busy}, 32'd0);
    chk("coinc_din", {24'd0, din}, 32'hA5);
    check_regs("coinc_regs");

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
      do_txn(bb, $urandom_range(1, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
